// File: rtl/dcache_refill_ctrl.sv
// dcache_refill_ctrl: data-cache miss handler.
// Writes back a dirty victim line, refills the missing line, then installs it.
module dcache_refill_ctrl #(
   parameter int ADDR_WIDTH      = 32,
   parameter int LINE_WORDS_LOG2 = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cpu_req,
   input  logic [ADDR_WIDTH-1:0]      mem_addr_i,
   input  logic                       hit,
   input  logic                       write_back,
   input  logic [ADDR_WIDTH-1:0]      last_addr,
   output logic [LINE_WORDS_LOG2-1:0] victim_word_sel,
   input  logic [31:0]                victim_rdata,
   output logic                       refill_we,
   output logic [LINE_WORDS_LOG2-1:0] refill_word_sel,
   output logic [31:0]                refill_wdata,
   output logic                       ram_ce,
   output logic                       ram_we,
   output logic [ADDR_WIDTH-1:0]      ram_addr,
   output logic [31:0]                ram_wdata,
   input  logic [31:0]                ram_rdata,
   input  logic                       ram_ready,
   output logic                       stall,
   output logic                       cache_ok
);

   localparam int OFF = LINE_WORDS_LOG2 + 2;
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF) - 1);

   typedef enum logic [1:0] {
      IDLE,
      WB,
      REFILL,
      DONE
   } state_t;

   state_t                     state, state_nxt;
   logic [LINE_WORDS_LOG2-1:0] cnt, cnt_nxt;
   logic [ADDR_WIDTH-1:0]      line_addr;
   logic [ADDR_WIDTH-1:0]      victim_addr;
   logic [ADDR_WIDTH-1:0]      word_off;
   logic                       miss;
   logic                       last_word;

   assign miss      = cpu_req & ~hit;
   assign last_word = (cnt == '1);
   // Bases are line-aligned, so OR-ing the offset can never carry upward.
   assign word_off  = ADDR_WIDTH'({cnt, 2'b00});

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         line_addr   <= '0;
         victim_addr <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == IDLE && miss) begin
            line_addr   <= mem_addr_i & ~OFF_MASK;
            victim_addr <= last_addr & ~OFF_MASK;
         end
      end
   end

   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      stall           = 1'b0;
      cache_ok        = 1'b0;
      ram_ce          = 1'b0;
      ram_we          = 1'b0;
      ram_addr        = '0;
      ram_wdata       = '0;
      victim_word_sel = '0;
      refill_we       = 1'b0;
      refill_word_sel = '0;
      refill_wdata    = '0;
      if (!rst) begin
         unique case (state)
            IDLE: begin
               stall = miss;
               if (miss) begin
                  state_nxt = write_back ? WB : REFILL;
                  cnt_nxt   = '0;
               end
            end
            WB: begin
               stall           = 1'b1;
               ram_ce          = 1'b1;
               ram_we          = 1'b1;
               ram_addr        = victim_addr | word_off;
               victim_word_sel = cnt;
               ram_wdata       = victim_rdata;
               if (ram_ready) begin
                  cnt_nxt = cnt + 1'b1;
                  if (last_word) state_nxt = REFILL;
               end
            end
            REFILL: begin
               stall           = 1'b1;
               ram_ce          = 1'b1;
               ram_addr        = line_addr | word_off;
               refill_we       = ram_ready;
               refill_word_sel = cnt;
               refill_wdata    = ram_rdata;
               if (ram_ready) begin
                  cnt_nxt = cnt + 1'b1;
                  if (last_word) state_nxt = DONE;
               end
            end
            DONE: begin
               stall     = 1'b1;
               cache_ok  = 1'b1;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// tb_dcache_refill_ctrl: scoreboard bench for the dcache miss controller.
// Stimulus queues expected bus/refill traffic; a monitor checks it.
module tb_dcache_refill_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req;
   logic [31:0] mem_addr_i;
   logic        hit;
   logic        write_back;
   logic [31:0] last_addr;
   logic [3:0]  victim_word_sel;
   logic [31:0] victim_rdata;
   logic        refill_we;
   logic [3:0]  refill_word_sel;
   logic [31:0] refill_wdata;
   logic        ram_ce;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic        ram_ready;
   logic        stall;
   logic        cache_ok;

   always #5 clk = ~clk;

   dcache_refill_ctrl #(
      .ADDR_WIDTH(32),
      .LINE_WORDS_LOG2(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cpu_req(cpu_req),
      .mem_addr_i(mem_addr_i),
      .hit(hit),
      .write_back(write_back),
      .last_addr(last_addr),
      .victim_word_sel(victim_word_sel),
      .victim_rdata(victim_rdata),
      .refill_we(refill_we),
      .refill_word_sel(refill_word_sel),
      .refill_wdata(refill_wdata),
      .ram_ce(ram_ce),
      .ram_we(ram_we),
      .ram_addr(ram_addr),
      .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata),
      .ram_ready(ram_ready),
      .stall(stall),
      .cache_ok(cache_ok)
   );

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic        last;
   } bus_t;

   typedef struct packed {
      logic [3:0]  sel;
      logic [31:0] data;
   } fill_t;

   bus_t        bus_q[$];
   fill_t       fill_q[$];
   logic [31:0] vmem[16];
   logic [31:0] seed;
   int          ready_pct;
   int          tick;
   int          n_cmp;
   int          n_bad;

   function automatic logic [31:0] mem_word(input logic [31:0] a,
                                            input logic [31:0] s);
      return (a * 32'h9E37_79B1) ^ s;
   endfunction

   assign victim_rdata = vmem[victim_word_sel];
   assign ram_rdata    = mem_word(ram_addr, seed);

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got event expected none", name);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Bus model: random acks, or every third cycle when ready_pct < 0.
   initial begin
      ram_ready = 1'b0;
      tick      = 0;
      forever begin
         @(posedge clk);
         #1;
         tick++;
         if (ready_pct < 0) ram_ready = (tick % 3 == 0);
         else ram_ready = (int'($urandom_range(0, 99)) < ready_pct);
      end
   end

   initial begin : monitor
      bit   ok_due;
      bus_t e;
      fill_t f;
      ok_due = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            ok_due = 1'b0;
         end else begin
            if (cache_ok || ok_due) begin
               chk("cache_ok", 32'(cache_ok), 32'(ok_due));
               if (cache_ok) chk("stall_done", 32'(stall), 32'd1);
            end
            ok_due = 1'b0;
            if (ram_ce) begin
               chk("stall_bus", 32'(stall), 32'd1);
               if (bus_q.size() == 0) begin
                  fail("unexpected_bus");
               end else begin
                  e = bus_q[0];
                  chk("ram_we", 32'(ram_we), 32'(e.we));
                  chk("ram_addr", ram_addr, e.addr);
                  if (e.we) chk("ram_wdata", ram_wdata, e.data);
                  if (ram_ready) begin
                     void'(bus_q.pop_front());
                     ok_due = e.last;
                  end
               end
            end
            if (refill_we) begin
               if (fill_q.size() == 0) begin
                  fail("unexpected_refill_we");
               end else begin
                  f = fill_q.pop_front();
                  chk("refill_sel", 32'(refill_word_sel), 32'(f.sel));
                  chk("refill_wdata", refill_wdata, f.data);
               end
            end
         end
      end
   end

   task automatic issue_miss(input logic dirty, input logic [31:0] addr,
                             input logic [31:0] victim);
      logic [31:0] lb;
      logic [31:0] vb;
      lb   = {addr[31:6], 6'b0};
      vb   = {victim[31:6], 6'b0};
      seed = $urandom;
      for (int i = 0; i < 16; i++) vmem[i] = $urandom;
      if (dirty)
         for (int i = 0; i < 16; i++)
            bus_q.push_back('{1'b1, vb + 32'(i * 4), vmem[i], 1'b0});
      for (int i = 0; i < 16; i++) begin
         bus_q.push_back('{1'b0, lb + 32'(i * 4), 32'h0, i == 15});
         fill_q.push_back('{4'(i), mem_word(lb + 32'(i * 4), seed)});
      end
      cpu_req    = 1'b1;
      hit        = 1'b0;
      write_back = dirty;
      mem_addr_i = addr;
      last_addr  = victim;
   endtask

   task automatic do_miss(input logic dirty, input logic [31:0] addr,
                          input logic [31:0] victim, input int exp_cyc);
      bit seen;
      issue_miss(dirty, addr, victim);
      seen = 1'b0;
      for (int n = 0; n < 3000 && !seen; n++) begin
         @(negedge clk);
         if (n == 0) chk("stall_miss", 32'(stall), 32'd1);
         if (cache_ok) begin
            seen = 1'b1;
            if (exp_cyc > 0) chk("ok_cycle", 32'(n), 32'(exp_cyc));
         end
         step();
         if (!seen) begin
            mem_addr_i = $urandom;
            last_addr  = $urandom;
            write_back = 1'($urandom);
            cpu_req    = 1'($urandom);
            hit        = 1'($urandom);
         end
      end
      if (!seen) fail("cache_ok_timeout");
      cpu_req    = 1'b1;
      hit        = 1'b1;
      mem_addr_i = addr;
      @(negedge clk);
      chk("stall_after_fill", 32'(stall), 32'd0);
      chk("ram_ce_after_fill", 32'(ram_ce), 32'd0);
      chk("bus_q_left", 32'(bus_q.size()), 32'd0);
      chk("fill_q_left", 32'(fill_q.size()), 32'd0);
      step();
      cpu_req = 1'b0;
   endtask

   initial begin : stimulus
      int acks;
      n_cmp      = 0;
      n_bad      = 0;
      ready_pct  = 100;
      seed       = 32'h0;
      rst        = 1'b1;
      cpu_req    = 1'b1;
      hit        = 1'b0;
      write_back = 1'b1;
      mem_addr_i = 32'h8000_1A48;
      last_addr  = 32'h1234_5A40;
      for (int i = 0; i < 16; i++) vmem[i] = 32'h0;
      step();
      @(negedge clk);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_ram_ce", 32'(ram_ce), 32'd0);
      chk("rst_cache_ok", 32'(cache_ok), 32'd0);
      chk("rst_refill_we", 32'(refill_we), 32'd0);
      chk("rst_ram_addr", ram_addr, 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      step();
      rst     = 1'b0;
      cpu_req = 1'b1;
      hit     = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hit_stall", 32'(stall), 32'd0);
         chk("hit_ram_ce", 32'(ram_ce), 32'd0);
         chk("hit_refill_we", 32'(refill_we), 32'd0);
         step();
      end
      cpu_req = 1'b0;
      step();

      do_miss(1'b0, 32'h8000_1A48, 32'h1234_5A40, 17);
      do_miss(1'b1, 32'h8000_1A48, 32'h1234_5A40, 33);
      ready_pct = -1;
      step();
      do_miss(1'b0, 32'h8000_1A48, 32'h1234_5A40, 0);
      ready_pct = 100;
      step();

      issue_miss(1'b0, 32'h0000_3F7C, 32'h0);
      acks = 0;
      for (int n = 0; n < 100 && acks < 5; n++) begin
         @(negedge clk);
         if (refill_we) acks++;
         step();
         cpu_req = 1'b0;
      end
      chk("acks_before_rst", 32'(acks), 32'd5);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_ram_ce", 32'(ram_ce), 32'd0);
      chk("abort_stall", 32'(stall), 32'd0);
      chk("abort_cache_ok", 32'(cache_ok), 32'd0);
      chk("abort_refill_we", 32'(refill_we), 32'd0);
      step();
      bus_q.delete();
      fill_q.delete();
      rst = 1'b0;
      step();
      do_miss(1'b0, 32'h0000_3F7C, 32'h0, 17);

      for (int t = 0; t < 20; t++) begin
         ready_pct = int'($urandom_range(20, 100));
         hit       = 1'b1;
         for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
            cpu_req = 1'($urandom);
            @(negedge clk);
            chk("idle_stall", 32'(stall), 32'd0);
            step();
         end
         do_miss(1'($urandom), $urandom, $urandom, 0);
      end

      repeat (3) step();
      chk("final_bus_q", 32'(bus_q.size()), 32'd0);
      chk("final_fill_q", 32'(fill_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
